// File: rtl/gnrl_fifo_lr.sv
// Valid/ready FIFO assembled from load-enable flop primitives. It supports
// synchronous flush, optional ready-path cutting, output masking and a DP=0 pass-through mode.

// Load-enable flop with active-low asynchronous reset to zero.
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;

  // capture on load enable, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= {DW{1'b0}};
    end else if (lden_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// Load-enable flop without reset, used for payload storage.
module gnrl_dffl #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          lden_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;

  // capture on load enable
  always_ff @(posedge clk) begin
    if (lden_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

module gnrl_fifo_lr #(
  parameter  int DW        = 32,
  parameter  int DP        = 4,
  parameter  int CUT_READY = 0,
  parameter  int MSKO      = 0,
  localparam int CW        = (DP < 1) ? 1 : $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [CW-1:0] count
);

  if (DW < 1 || DP < 0) begin : g_param_err
    $error("gnrl_fifo_lr: illegal parameters DW=%0d DP=%0d", DW, DP);
  end

  if (DP == 0) begin : g_pass
    // No storage: the handshake and data connect straight through.
    logic unused_s;
    assign unused_s = ^{clk, rst_n, flush};

    assign o_vld = i_vld;
    assign i_rdy = o_rdy;
    assign count = {CW{1'b0}};
    assign o_dat = ((MSKO != 0) && !i_vld) ? {DW{1'b0}} : i_dat;

  end else begin : g_fifo
    localparam int PW = (DP <= 1) ? 1 : $clog2(DP);
    localparam logic [PW-1:0] PTR_LAST = PW'(DP - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DP);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wen_s, ren_s, full_s, empty_s;
    logic          wptr_ld_s, rptr_ld_s, count_ld_s;
    logic [DP-1:0] we_s;
    logic [DW-1:0] mem_q [DP];
    logic [DW-1:0] rdat_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == {CW{1'b0}});

    assign o_vld = ~empty_s & ~flush;
    // With CUT_READY=0 a full FIFO still accepts when the consumer frees a slot.
    assign i_rdy = (CUT_READY != 0) ? (~full_s & ~flush)
                                    : ((~full_s | o_rdy) & ~flush);

    assign wen_s = i_vld & i_rdy;
    assign ren_s = o_vld & o_rdy;

    // next-state for pointers and occupancy; flush overrides everything
    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
        wptr_d  = {PW{1'b0}};
        rptr_d  = {PW{1'b0}};
        count_d = {CW{1'b0}};
      end else begin
        if (wen_s) begin
          wptr_d = (wptr_q == PTR_LAST) ? {PW{1'b0}} : wptr_q + PW'(1);
        end else begin
          wptr_d = wptr_q;
        end
        if (ren_s) begin
          rptr_d = (rptr_q == PTR_LAST) ? {PW{1'b0}} : rptr_q + PW'(1);
        end else begin
          rptr_d = rptr_q;
        end
        case ({wen_s, ren_s})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end

    assign wptr_ld_s  = flush | wen_s;
    assign rptr_ld_s  = flush | ren_s;
    assign count_ld_s = flush | (wen_s ^ ren_s);

    gnrl_dfflr #(.DW(PW)) u_wptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .lden_i (wptr_ld_s),
      .d_i    (wptr_d),
      .q_o    (wptr_q)
    );

    gnrl_dfflr #(.DW(PW)) u_rptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .lden_i (rptr_ld_s),
      .d_i    (rptr_d),
      .q_o    (rptr_q)
    );

    gnrl_dfflr #(.DW(CW)) u_count (
      .clk    (clk),
      .rst_n  (rst_n),
      .lden_i (count_ld_s),
      .d_i    (count_d),
      .q_o    (count_q)
    );

    for (genvar i = 0; i < DP; i++) begin : g_mem
      assign we_s[i] = wen_s & (wptr_q == PW'(i));

      gnrl_dffl #(.DW(DW)) u_ent (
        .clk    (clk),
        .lden_i (we_s[i]),
        .d_i    (i_dat),
        .q_o    (mem_q[i])
      );
    end

    // head-of-queue read mux
    always_comb begin
      rdat_s = {DW{1'b0}};
      for (int i = 0; i < DP; i++) begin
        rdat_s = (rptr_q == PW'(i)) ? mem_q[i] : rdat_s;
      end
    end

    assign o_dat = ((MSKO != 0) && !o_vld) ? {DW{1'b0}} : rdat_s;
    assign count = count_q;
  end

endmodule
